// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the registered 16-bit ALU: issues one
// operation, waits for the selected unit's flag (or times out) and returns the result.
module alu_req_arbiter #(
   parameter int IN_DATA_WIDTH  = 16,
   parameter int OUT_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYC    = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [3:0]                req0_func,
   input  logic [3:0]                req1_func,
   input  logic [IN_DATA_WIDTH-1:0]  req0_a,
   input  logic [IN_DATA_WIDTH-1:0]  req0_b,
   input  logic [IN_DATA_WIDTH-1:0]  req1_a,
   input  logic [IN_DATA_WIDTH-1:0]  req1_b,
   output logic [1:0]                rsp_valid,
   input  logic [1:0]                rsp_ready,
   output logic [OUT_DATA_WIDTH-1:0] rsp_data,
   output logic                      rsp_carry,
   output logic                      rsp_err,
   output logic                      busy,
   output logic [IN_DATA_WIDTH-1:0]  alu_a,
   output logic [IN_DATA_WIDTH-1:0]  alu_b,
   output logic [3:0]                alu_func,
   input  logic [OUT_DATA_WIDTH-1:0] arith_out,
   input  logic                      carry_out,
   input  logic                      arith_flag,
   input  logic [IN_DATA_WIDTH-1:0]  logic_out,
   input  logic                      logic_flag,
   input  logic [IN_DATA_WIDTH-1:0]  shift_out,
   input  logic                      shift_flag,
   input  logic [2:0]                cmp_out,
   input  logic                      cmp_flag
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                     state_q, state_d;
   logic                       last_q, last_d;
   logic                       owner_q, owner_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IN_DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [IN_DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [3:0]                 alu_func_q, alu_func_d;
   logic [1:0]                 rsp_valid_q, rsp_valid_d;
   logic [OUT_DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                       rsp_carry_q, rsp_carry_d;
   logic                       rsp_err_q, rsp_err_d;
   logic                       busy_q, busy_d;

   logic [1:0]                 grant;
   logic                       unit_flag;
   logic [OUT_DATA_WIDTH-1:0]  unit_data;
   logic                       unit_is_arith;
   logic [1:0]                 owner_onehot;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Gated by RST so no accept is advertised while reset is held.
   assign req_ready = (RST && state_q == S_IDLE) ? grant : 2'b00;

   always_comb begin
      unit_flag = 1'b0;
      unit_data = '0;
      case (alu_func_q[3:2])
         2'b00: begin
            unit_flag = arith_flag;
            unit_data = arith_out;
         end
         2'b01: begin
            unit_flag = logic_flag;
            unit_data = OUT_DATA_WIDTH'(logic_out);
         end
         2'b10: begin
            unit_flag = cmp_flag;
            unit_data = OUT_DATA_WIDTH'(cmp_out);
         end
         default: begin
            unit_flag = shift_flag;
            unit_data = OUT_DATA_WIDTH'(shift_out);
         end
      endcase
   end

   assign unit_is_arith = (alu_func_q[3:2] == 2'b00);
   assign owner_onehot  = owner_q ? 2'b10 : 2'b01;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_func_d  = alu_func_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (|(req_valid & req_ready)) begin
               owner_d    = req_ready[1];
               last_d     = req_ready[1];
               alu_func_d = req_ready[1] ? req1_func : req0_func;
               alu_a_d    = req_ready[1] ? req1_a : req0_a;
               alu_b_d    = req_ready[1] ? req1_b : req0_b;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (unit_flag) begin
               rsp_data_d  = unit_data;
               rsp_carry_d = unit_is_arith & carry_out;
               rsp_err_d   = 1'b0;
               rsp_valid_d = owner_onehot;
               state_d     = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               rsp_data_d  = '0;
               rsp_carry_d = 1'b0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = owner_onehot;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            // Only the owner's ready bit closes the response.
            if (rsp_ready[owner_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = S_IDLE;
            end
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_func_q  <= '0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_func_q  <= alu_func_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_func  = alu_func_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a stand-in registered ALU, directed vector table,
// hand-written timeout/reset sequences and randomized traffic against a reference model.
module tb_alu_req_arbiter;

   localparam int IW = 16;
   localparam int OW = 32;
   localparam int TO = 8;

   logic           CLK = 1'b0;
   logic           RST;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [3:0]     req0_func, req1_func;
   logic [IW-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [1:0]     rsp_valid;
   logic [1:0]     rsp_ready;
   logic [OW-1:0]  rsp_data;
   logic           rsp_carry, rsp_err, busy;
   logic [IW-1:0]  alu_a, alu_b;
   logic [3:0]     alu_func;
   logic [OW-1:0]  arith_out;
   logic           carry_out, arith_flag;
   logic [IW-1:0]  logic_out, shift_out;
   logic           logic_flag, shift_flag;
   logic [2:0]     cmp_out;
   logic           cmp_flag;

   int checks = 0;
   int errors = 0;
   int last_m = 1;
   bit suppress = 1'b0;

   always #5 CLK = ~CLK;

   alu_req_arbiter #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_func(req0_func), .req1_func(req1_func),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .arith_out(arith_out), .carry_out(carry_out), .arith_flag(arith_flag),
      .logic_out(logic_out), .logic_flag(logic_flag),
      .shift_out(shift_out), .shift_flag(shift_flag),
      .cmp_out(cmp_out), .cmp_flag(cmp_flag)
   );

   // Stand-in ALU: every unit computes every cycle; only the selected unit's flag is
   // meaningful, the others toggle randomly so a wrong selection shows up.
   logic [16:0] add17, sub17, rsub17;
   logic [3:0]  sh;
   assign add17  = {1'b0, alu_a} + {1'b0, alu_b};
   assign sub17  = {1'b0, alu_a} - {1'b0, alu_b};
   assign rsub17 = {1'b0, alu_b} - {1'b0, alu_a};
   assign sh     = alu_b[3:0];

   always @(posedge CLK) begin
      case (alu_func[1:0])
         2'd0: begin arith_out <= {15'h0, add17}; carry_out <= add17[16]; end
         2'd1: begin arith_out <= {{16{sub17[16]}}, sub17[15:0]}; carry_out <= sub17[16]; end
         2'd2: begin arith_out <= {16'h0, alu_a} * {16'h0, alu_b}; carry_out <= 1'b0; end
         default: begin arith_out <= {{16{rsub17[16]}}, rsub17[15:0]}; carry_out <= rsub17[16]; end
      endcase
      case (alu_func[1:0])
         2'd0: logic_out <= alu_a & alu_b;
         2'd1: logic_out <= alu_a | alu_b;
         2'd2: logic_out <= alu_a ^ alu_b;
         default: logic_out <= ~(alu_a & alu_b);
      endcase
      case (alu_func[1:0])
         2'd0: shift_out <= alu_a << sh;
         2'd1: shift_out <= alu_a >> sh;
         2'd2: shift_out <= (alu_a << sh) | (alu_a >> (5'd16 - {1'b0, sh}));
         default: shift_out <= (alu_a >> sh) | (alu_a << (5'd16 - {1'b0, sh}));
      endcase
      cmp_out    <= {alu_a > alu_b, alu_a == alu_b, alu_a < alu_b};
      arith_flag <= (alu_func[3:2] == 2'd0) ? !suppress : 1'($urandom_range(0, 1));
      logic_flag <= (alu_func[3:2] == 2'd1) ? !suppress : 1'($urandom_range(0, 1));
      cmp_flag   <= (alu_func[3:2] == 2'd2) ? !suppress : 1'($urandom_range(0, 1));
      shift_flag <= (alu_func[3:2] == 2'd3) ? !suppress : 1'($urandom_range(0, 1));
   end

   // Reference result of one operation, from the operation's meaning alone.
   function automatic void ref_rsp(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                   output logic [31:0] d, output logic c);
      longint sa, sb, r;
      logic [15:0] t;
      int n;
      sa = longint'(a);
      sb = longint'(b);
      n  = int'(b[3:0]);
      c  = 1'b0;
      d  = '0;
      r  = 0;
      t  = a;
      case (f[3:2])
         2'd0: begin
            case (f[1:0])
               2'd0: begin r = sa + sb; c = (r > 65535); end
               2'd1: begin r = sa - sb; c = (sa < sb); end
               2'd2: r = sa * sb;
               default: begin r = sb - sa; c = (sb < sa); end
            endcase
            d = r[31:0];
         end
         2'd1: begin
            case (f[1:0])
               2'd0: t = a & b;
               2'd1: t = a | b;
               2'd2: t = a ^ b;
               default: t = ~(a & b);
            endcase
            d = {16'h0, t};
         end
         2'd2: d = (a > b) ? 32'd4 : ((a == b) ? 32'd2 : 32'd1);
         default: begin
            case (f[1:0])
               2'd0: repeat (n) t = {t[14:0], 1'b0};
               2'd1: repeat (n) t = {1'b0, t[15:1]};
               2'd2: repeat (n) t = {t[14:0], t[15]};
               default: repeat (n) t = {t[0], t[15:1]};
            endcase
            d = {16'h0, t};
         end
      endcase
   endfunction

   function automatic int grant_m(input logic [1:0] vm);
      if (vm == 2'b01) return 0;
      if (vm == 2'b10) return 1;
      return (last_m == 1) ? 0 : 1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One full operation; entered and left on a negative clock edge.
   task automatic txn(input logic [1:0] vm, input logic [3:0] f0, input logic [3:0] f1,
                      input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1,
                      input int stall, input bit supp, input logic [1:0] extra,
                      input int eown, input logic [31:0] ed, input logic ec, input logic ee,
                      input string tag);
      logic [1:0] oh;
      int n;
      int exp_n;
      oh    = (eown == 1) ? 2'b10 : 2'b01;
      exp_n = ee ? TO + 2 : 3;
      suppress  = supp;
      req_valid = vm;
      req0_func = f0; req0_a = a0; req0_b = b0;
      req1_func = f1; req1_a = a1; req1_b = b1;
      rsp_ready = 2'b00;
      #1;
      chk({tag, " req_ready"}, 64'(req_ready), 64'(oh));
      @(posedge CLK);
      last_m = eown;
      n = 0;
      while (n < 40) begin
         @(negedge CLK);
         n++;
         if (n == 1) begin
            chk({tag, " busy_issue"}, 64'(busy), 64'(1));
            chk({tag, " req_ready_busy"}, 64'(req_ready), 64'(0));
         end
         if (rsp_valid !== 2'b00) break;
      end
      chk({tag, " latency"}, 64'(n), 64'(exp_n));
      chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(oh));
      chk({tag, " rsp_data"}, 64'(rsp_data), 64'(ed));
      chk({tag, " rsp_carry"}, 64'(rsp_carry), 64'(ec));
      chk({tag, " rsp_err"}, 64'(rsp_err), 64'(ee));
      for (int i = 0; i < stall; i++) begin
         rsp_ready = extra & ~oh;
         @(posedge CLK);
         @(negedge CLK);
         chk({tag, " hold_valid"}, 64'(rsp_valid), 64'(oh));
         chk({tag, " hold_data"}, 64'(rsp_data), 64'(ed));
         chk({tag, " hold_busy"}, 64'(busy), 64'(1));
         chk({tag, " hold_req_ready"}, 64'(req_ready), 64'(0));
      end
      rsp_ready = oh | extra;
      @(posedge CLK);
      @(negedge CLK);
      rsp_ready = 2'b00;
      req_valid = 2'b00;
      chk({tag, " rsp_valid_clr"}, 64'(rsp_valid), 64'(0));
      chk({tag, " busy_clr"}, 64'(busy), 64'(0));
      $display("txn %s: owner=%0d data=0x%08h carry=%0d err=%0d latency=%0d",
               tag, eown, ed, ec, ee, n);
   endtask

   typedef struct {
      logic [1:0]  vm;
      logic [3:0]  f0, f1;
      logic [15:0] a0, b0, a1, b1;
      int          stall;
      int          eown;
      logic [31:0] ed;
      logic        ec;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  vm;
      logic [3:0]  f0, f1;
      logic [15:0] a0, b0, a1, b1;
      logic [31:0] ed;
      logic        ec;
      bit          supp;
      int          eown;

      vecs[0] = '{2'b01, 4'b0000, 4'b0000, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 0, 0, 32'h0000_0007, 1'b0};
      vecs[1] = '{2'b10, 4'b0000, 4'b0100, 16'h0000, 16'h0000, 16'hFF0F, 16'h0FF0, 0, 1, 32'h0000_0F00, 1'b0};
      vecs[2] = '{2'b11, 4'b0001, 4'b0000, 16'h0005, 16'h0007, 16'h1111, 16'h2222, 0, 0, 32'hFFFF_FFFE, 1'b1};
      vecs[3] = '{2'b11, 4'b0000, 4'b1000, 16'h1234, 16'h0001, 16'h0009, 16'h0009, 0, 1, 32'h0000_0002, 1'b0};
      vecs[4] = '{2'b11, 4'b1110, 4'b0000, 16'h8001, 16'h0001, 16'h3333, 16'h4444, 0, 0, 32'h0000_0003, 1'b0};
      vecs[5] = '{2'b11, 4'b0000, 4'b0010, 16'h5555, 16'h6666, 16'h1234, 16'h0100, 0, 1, 32'h0012_3400, 1'b0};
      vecs[6] = '{2'b01, 4'b0000, 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 0, 32'h0001_0000, 1'b1};
      vecs[7] = '{2'b10, 4'b0000, 4'b0110, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 2, 1, 32'h0000_FFFE, 1'b0};
      vecs[8] = '{2'b01, 4'b1101, 4'b0000, 16'h8000, 16'h000F, 16'h0000, 16'h0000, 5, 0, 32'h0000_0001, 1'b0};

      RST = 1'b0;
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      req0_func = '0; req1_func = '0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(negedge CLK);
      chk("rst req_ready", 64'(req_ready), 64'(0));
      chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst rsp_data", 64'(rsp_data), 64'(0));
      chk("rst rsp_carry_err", 64'({rsp_carry, rsp_err}), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst alu", 64'({alu_a, alu_b, alu_func}), 64'(0));
      req_valid = 2'b00;
      RST = 1'b1;
      @(negedge CLK);

      foreach (vecs[i]) begin
         txn(vecs[i].vm, vecs[i].f0, vecs[i].f1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
             vecs[i].stall, 1'b0, 2'b11, vecs[i].eown, vecs[i].ed, vecs[i].ec, 1'b0,
             $sformatf("vec%0d", i));
      end

      txn(2'b10, 4'b0000, 4'b0101, 16'h0, 16'h0, 16'h00F0, 16'h0F00, 1, 1'b1, 2'b00,
          1, 32'h0, 1'b0, 1'b1, "timeout");

      // Reset while waiting on a flag that never comes.
      suppress  = 1'b1;
      req_valid = 2'b01;
      req0_func = 4'b0101; req0_a = 16'h1111; req0_b = 16'h2222;
      @(posedge CLK);
      repeat (3) @(negedge CLK);
      chk("pre_rst busy", 64'(busy), 64'(1));
      RST = 1'b0;
      #1;
      chk("mid_rst req_ready", 64'(req_ready), 64'(0));
      chk("mid_rst rsp_valid", 64'(rsp_valid), 64'(0));
      chk("mid_rst rsp_data", 64'(rsp_data), 64'(0));
      chk("mid_rst busy", 64'(busy), 64'(0));
      chk("mid_rst alu", 64'({alu_a, alu_b, alu_func}), 64'(0));
      @(negedge CLK);
      req_valid = 2'b00;
      suppress  = 1'b0;
      RST = 1'b1;
      last_m = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("post_rst quiet", 64'({rsp_valid, busy}), 64'(0));
      end
      txn(2'b11, 4'b0000, 4'b0000, 16'h0010, 16'h0020, 16'h0001, 16'h0002, 0, 1'b0, 2'b00,
          0, 32'h0000_0030, 1'b0, 1'b0, "post_rst_tie");

      for (int k = 0; k < 40; k++) begin
         vm = 2'($urandom_range(1, 3));
         f0 = 4'($urandom); f1 = 4'($urandom);
         a0 = 16'($urandom); b0 = 16'($urandom);
         a1 = 16'($urandom); b1 = 16'($urandom);
         supp = ($urandom_range(0, 9) == 0);
         eown = grant_m(vm);
         if (supp) begin
            ed = '0;
            ec = 1'b0;
         end else if (eown == 1) begin
            ref_rsp(f1, a1, b1, ed, ec);
         end else begin
            ref_rsp(f0, a0, b0, ed, ec);
         end
         txn(vm, f0, f1, a0, b0, a1, b1, int'($urandom_range(0, 3)), supp, 2'($urandom),
             eown, ed, ec, supp, $sformatf("rnd%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the registered 16-bit ALU between two requesters and sequences each operation through it.
- Arbitrates round-robin, then drives A/B/ALU_FUNC for one operation.
- Waits for the selected unit's registered flag, captures and normalises the result to 32 bits, and returns it to the owning requester with a valid/ready handshake.
- Sits between the two command sources and the ALU top level. The ALU's four unit outputs and flags connect directly to this block.

Parameters:
IN_DATA_WIDTH, 16, operand width
OUT_DATA_WIDTH, 32, response data width (equals arithmetic output width)
TIMEOUT_CYC, 8, max cycles to wait for the unit flag before reporting an error (>=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester command valid (bit i = requester i)
req_ready  out  2  per-requester command accept
req0_func / req1_func  in  4 each  ALU_FUNC of requester 0/1
req0_a, req0_b / req1_a, req1_b  in  IN_DATA_WIDTH each  operands
rsp_valid  out  2  one-hot response valid to the owning requester
rsp_ready  in  2  per-requester response accept
rsp_data  out  OUT_DATA_WIDTH  result
rsp_carry  out  1  carry (arithmetic ops only, else 0)
rsp_err  out  1  timeout error
busy  out  1  high in any state other than IDLE
alu_a, alu_b  out  IN_DATA_WIDTH  to ALU A/B
alu_func  out  4  to ALU ALU_FUNC
arith_out  in  32; carry_out, arith_flag  in 1
logic_out  in  16; logic_flag  in 1
shift_out  in  16; shift_flag  in 1
cmp_out  in  3; cmp_flag  in 1

Behaviour:
- Reset (RST=0, async):
  - State IDLE, grant pointer last=1, so requester 0 wins first.
  - Outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_err=0, busy=0, alu_a/alu_b/alu_func=0.
  - Reset mid-operation discards the transaction; no response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant, combinational: if only one req_valid bit is set, grant it. If both are set, grant the requester != last.
  - req_ready is asserted only for the granted requester, and only in IDLE.
  - On handshake (valid & ready): register func/a/b onto alu_*, set owner and last=owner, go to ISSUE.
- ISSUE (1 cycle): alu_* stable; the ALU registers the result at the end of this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Selected unit by func[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
  - If that unit's flag=1:
    - Capture rsp_data: arith_out (full 32 bits), or logic_out/shift_out/cmp_out zero-extended.
    - rsp_carry = carry_out for arith, else 0. rsp_err=0. Go to RESP.
  - Else increment the counter. When counter == TIMEOUT_CYC-1, capture rsp_data=0, rsp_carry=0, rsp_err=1 and go to RESP.
- RESP:
  - rsp_valid[owner]=1. rsp_data/carry/err are held stable until rsp_ready[owner]=1.
  - On handshake: rsp_valid=0, go to IDLE.
  - The next accept occurs no earlier than the following cycle.
  - rsp_ready on the non-owner bit is ignored.
- alu_a/alu_b/alu_func hold their last values in IDLE and RESP (no toggling). Flags from unselected units are ignored.
- Latency: accept edge E0 -> ALU samples at E1 -> rsp_valid high after E2 (flag arrives normally).
- Peak throughput: one operation per 4 cycles.
- A requester may drop req_valid before being granted; there is no commitment before the handshake.

Test Plan:
1. Reset, req0 ADD func=0000 A=0x0003 B=0x0004 -> req_ready[0] same cycle; rsp_valid=2'b01 after 2 edges; rsp_data=0x00000007, rsp_carry=0, rsp_err=0.
2. req1 AND func=0100 A=0xFF0F B=0x0FF0 -> rsp_valid=2'b10, rsp_data=0x00000F00 (zero-extended), rsp_carry=0.
3. Both req_valid held high from reset, 4 operations -> grant order 0,1,0,1; rsp_valid one-hot matches owner each time.
4. Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=2'b00, busy=1. On ready, busy=0 next cycle.
5. Bench ALU model suppresses flags, TIMEOUT_CYC=8 -> rsp_valid asserted with rsp_err=1, rsp_data=0 exactly 8 cycles after entering WAIT.
6. RST asserted during WAIT -> all outputs 0 immediately. After release: no stale response, state IDLE, requester 0 wins the next tie.
